// File: rtl/cam_pkg.sv
// Shared defaults and state encoding for the OV2640 capture stage.
package cam_pkg;

    localparam int CAM_H_RES     = 320;
    localparam int CAM_V_RES     = 240;
    localparam int CAM_FB_PIXELS = CAM_H_RES * CAM_V_RES;
    localparam int CAM_ADDR_W    = 17;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        SKIP      = 2'd1,
        CAPTURE   = 2'd2
    } cap_state_t;

endpackage

// File: rtl/ov2640_capture.sv
// OV2640 byte stream to RGB565 pixel writes for a linear frame buffer.
// Frame skip after reset, frame-done pulse and sticky geometry error flag.
//
// state     | meaning
// WAIT_SYNC | idle until the next vs_act falling edge (frame start)
// SKIP      | discarding a settle frame; count it at the vs_act rise
// CAPTURE   | assembling pixels and issuing buffer writes
module ov2640_capture
    import cam_pkg::*;
#(
    parameter int H_RES          = CAM_H_RES,
    parameter int V_RES          = CAM_V_RES,
    parameter int ADDR_W         = CAM_ADDR_W,
    parameter int SKIP_FRAMES    = 2,
    parameter bit VSYNC_ACT_HIGH = 1'b1
) (
    input  logic              dclk,
    input  logic              rst_n,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_d,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int X_W    = $clog2(H_RES + 1);
    localparam int Y_W    = $clog2(V_RES + 1);
    localparam int SKIP_W = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);

    localparam logic [X_W-1:0]    X_MAX    = X_W'(H_RES);
    localparam logic [Y_W-1:0]    Y_MAX    = Y_W'(V_RES);
    localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(SKIP_FRAMES);
    localparam logic [ADDR_W-1:0] H_STEP   = ADDR_W'(H_RES);

    cap_state_t          r_state, w_state_nxt;
    logic [SKIP_W-1:0]   r_skip_cnt;
    logic                r_vs_q, r_href_q, r_phase;
    logic [7:0]          r_hi;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [ADDR_W-1:0]   r_addr, r_line_base;
    logic                r_pix_vld;
    logic [ADDR_W-1:0]   r_pix_addr;
    logic [15:0]         r_pix_data;
    logic                r_wr_en, r_frame_done, r_frame_err;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [15:0]         r_wr_data;

    logic w_vs_act, w_vs_rise, w_vs_fall, w_href_fall;
    logic w_cap, w_line_err, w_pix_ok, w_y_done;

    assign w_vs_act    = cam_vsync ^ !VSYNC_ACT_HIGH;
    assign w_vs_rise   = w_vs_act & ~r_vs_q;
    assign w_vs_fall   = ~w_vs_act & r_vs_q;
    assign w_href_fall = r_href_q & ~cam_href;
    assign w_cap       = (r_state == CAPTURE);
    assign w_line_err  = (r_x != X_MAX) || r_phase;
    assign w_pix_ok    = (r_x < X_MAX) && (r_y < Y_MAX);
    // a line closing on the same edge as the vs_act rise still counts
    assign w_y_done    = (r_y == Y_MAX) || (w_href_fall && (r_y == Y_MAX - Y_W'(1)));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_SYNC: if (w_vs_fall) w_state_nxt = (r_skip_cnt < SKIP_MAX) ? SKIP : CAPTURE;
            SKIP:      if (w_vs_rise) w_state_nxt = WAIT_SYNC;
            CAPTURE:   if (w_vs_rise) w_state_nxt = WAIT_SYNC;
            default:   w_state_nxt = WAIT_SYNC;
        endcase
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= WAIT_SYNC;
            r_skip_cnt <= '0;
            r_vs_q     <= 1'b0;
            r_href_q   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_vs_q   <= w_vs_act;
            r_href_q <= cam_href;
            if (r_state == SKIP && w_vs_rise && r_skip_cnt < SKIP_MAX)
                r_skip_cnt <= r_skip_cnt + SKIP_W'(1);
        end
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= 1'b0;
            r_hi         <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_addr       <= '0;
            r_line_base  <= '0;
            r_pix_vld    <= 1'b0;
            r_pix_addr   <= '0;
            r_pix_data   <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_pix_vld    <= 1'b0;
            r_frame_done <= 1'b0;
            if (!w_cap || !cam_href) begin
                r_phase <= 1'b0;
            end else begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_hi <= cam_d;
                end else begin
                    if (w_pix_ok) begin
                        r_pix_vld  <= 1'b1;
                        r_pix_addr <= r_addr;
                        r_pix_data <= {r_hi, cam_d};
                        r_addr     <= r_addr + ADDR_W'(1);
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                    if (r_x < X_MAX) r_x <= r_x + X_W'(1);
                end
            end
            if (w_cap && w_href_fall) begin
                if (w_line_err) r_frame_err <= 1'b1;
                r_x <= '0;
                // realign to the next line base so a bad line cannot skew later ones
                if (r_y < Y_MAX) begin
                    r_y         <= r_y + Y_W'(1);
                    r_line_base <= r_line_base + H_STEP;
                    r_addr      <= r_line_base + H_STEP;
                end
            end
            if (w_cap && w_vs_rise) begin
                r_frame_done <= 1'b1;
                if (!w_y_done || cam_href) r_frame_err <= 1'b1;
                r_x         <= '0;
                r_y         <= '0;
                r_addr      <= '0;
                r_line_base <= '0;
                r_phase     <= 1'b0;
            end
        end
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en   <= r_pix_vld;
            r_wr_addr <= r_pix_addr;
            r_wr_data <= r_pix_data;
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ov2640_capture.sv
// Scoreboard bench for ov2640_capture on a reduced 8x4 frame.
module tb_ov2640_capture;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int AW   = 5;
    localparam int SKIP = 2;

    logic          dclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cam_vsync = 1'b1;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_d = 8'h00;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          frame_done;
    logic          frame_err;

    ov2640_capture #(
        .H_RES(H), .V_RES(V), .ADDR_W(AW), .SKIP_FRAMES(SKIP), .VSYNC_ACT_HIGH(1'b1)
    ) dut (
        .dclk(dclk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_d(cam_d), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 dclk = ~dclk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        int            cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          frames_since_rst = 0;
    logic        prev_wr = 1'b0;
    logic [15:0] first_data = '0;
    bit          first_seen = 0;
    bit          force_f81f = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge dclk) cyc <= cyc + 1;

    always @(negedge dclk) begin
        exp_t e;
        if (rst_n) begin
            if (wr_en) begin
                chk_eq("wr_b2b", prev_wr, 0);
                chk_eq("sb_pending", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk_eq("wr_addr", wr_addr, e.addr);
                    chk_eq("wr_data", wr_data, e.data);
                    chk_eq("wr_cyc", cyc, e.cyc);
                end
                wr_cnt++;
                if (!first_seen) begin
                    first_data = wr_data;
                    first_seen = 1;
                end
            end
            if (frame_done) done_cnt++;
            prev_wr = wr_en;
        end else begin
            prev_wr = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    // Drives one byte; on odd bytes records the expected write if it is in range.
    task automatic drive_byte(input int i, input int y, input bit cap, inout logic [7:0] hi);
        logic [7:0] b;
        exp_t e;
        b = 8'($urandom_range(0, 255));
        if (force_f81f && y == 0 && i < 2) b = (i == 0) ? 8'hF8 : 8'h1F;
        cam_href = 1'b1;
        cam_d    = b;
        if (i % 2 == 0) begin
            hi = b;
        end else if (cap && (i / 2) < H && y < V) begin
            e.addr = AW'(y * H + i / 2);
            e.data = {hi, b};
            e.cyc  = cyc + 2;
            sb.push_back(e);
        end
        tick();
    endtask

    task automatic send_line(input int nbytes, input int y, input bit cap);
        logic [7:0] hi;
        hi = 8'h00;
        for (int i = 0; i < nbytes; i++) drive_byte(i, y, cap, hi);
        cam_href = 1'b0;
        cam_d    = 8'h00;
        repeat (3) tick();
    endtask

    task automatic send_frame(input int nlines, input int long_y, input int odd_y);
        bit cap;
        int nb;
        cap = (frames_since_rst >= SKIP);
        cam_vsync = 1'b1;
        repeat (4) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
        for (int y = 0; y < nlines; y++) begin
            nb = (y == long_y) ? 2 * (H + 2) : ((y == odd_y) ? 2 * H + 1 : 2 * H);
            send_line(nb, y, cap);
        end
        cam_vsync = 1'b1;
        repeat (4) tick();
        frames_since_rst++;
    endtask

    task automatic full_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        sb.delete();
        frames_since_rst = 0;
        wr_cnt   = 0;
        done_cnt = 0;
    endtask

    initial begin
        logic [7:0] hi;
        repeat (3) tick();
        chk_eq("rst_wr_en", wr_en, 0);
        chk_eq("rst_wr_addr", wr_addr, 0);
        chk_eq("rst_wr_data", wr_data, 0);
        chk_eq("rst_frame_done", frame_done, 0);
        chk_eq("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        tick();

        // two settle frames, then a clean captured frame led by an F8/1F pixel
        send_frame(V, -1, -1);
        send_frame(V, -1, -1);
        chk_eq("skip_wr_cnt", wr_cnt, 0);
        chk_eq("skip_done_cnt", done_cnt, 0);
        force_f81f = 1;
        first_seen = 0;
        send_frame(V, -1, -1);
        force_f81f = 0;
        chk_eq("cap_wr_cnt", wr_cnt, H * V);
        chk_eq("cap_done_cnt", done_cnt, 1);
        chk_eq("cap_frame_err", frame_err, 0);
        chk_eq("cap_f81f", first_data, 16'hF81F);
        chk_eq("cap_sb_empty", sb.size(), 0);

        // one over-long line: extra pixels dropped, later lines still aligned
        wr_cnt = 0;
        send_frame(V, 1, -1);
        chk_eq("long_wr_cnt", wr_cnt, H * V);
        chk_eq("long_done_cnt", done_cnt, 2);
        chk_eq("long_frame_err", frame_err, 1);
        chk_eq("long_sb_empty", sb.size(), 0);

        // reset asserted in the middle of a line while a strobe is out
        cam_vsync = 1'b1;
        repeat (4) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
        hi = 8'h00;
        for (int i = 0; i < 7; i++) drive_byte(i, 0, 1'b1, hi);
        chk_eq("pre_rst_wr_en", wr_en, 1);
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_wr_en", wr_en, 0);
        chk_eq("mid_rst_wr_addr", wr_addr, 0);
        chk_eq("mid_rst_wr_data", wr_data, 0);
        chk_eq("mid_rst_frame_done", frame_done, 0);
        chk_eq("mid_rst_frame_err", frame_err, 0);
        cam_href = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        frames_since_rst = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        send_frame(V, -1, -1);
        send_frame(V, -1, -1);
        chk_eq("rst_skip_wr_cnt", wr_cnt, 0);

        // short frame, then a full frame that must restart at address 0
        send_frame(V - 1, -1, -1);
        chk_eq("short_wr_cnt", wr_cnt, H * (V - 1));
        chk_eq("short_done_cnt", done_cnt, 1);
        chk_eq("short_frame_err", frame_err, 1);
        send_frame(V, -1, -1);
        chk_eq("after_short_wr_cnt", wr_cnt, H * (2 * V - 1));
        chk_eq("after_short_sb_empty", sb.size(), 0);

        // odd byte count on line 0; line 1 onward must realign
        full_reset();
        send_frame(V, -1, -1);
        send_frame(V, -1, -1);
        chk_eq("odd_pre_err", frame_err, 0);
        send_frame(V, -1, 0);
        chk_eq("odd_frame_err", frame_err, 1);
        chk_eq("odd_wr_cnt", wr_cnt, H * V);
        chk_eq("odd_done_cnt", done_cnt, 1);
        chk_eq("odd_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
